// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 raster constants and window helper
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int CNT_W_DEF    = 10;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Sync pulses start right after the front porch; the end bound is exclusive.
    localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
    localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

    // Values of SYNC_POL: the level the sync pins take while asserted.
    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    // True when pos lies in the half-open window [lo, hi).
    function automatic bit in_window(input int pos, input int lo, input int hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - modulo-MAX position counter with wrap pulse
module vga_axis_counter #(
    parameter int MAX = 800,
    parameter int W   = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    // Wrap is combinational so the next axis can advance on the same edge.
    assign wrap = inc && (count == LAST);

    // Advance on inc, folding MAX-1 back to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: syncs, blanking, coordinates, strobes
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = SYNC_ACTIVE_LOW,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             pixel_clk,
    input  logic             reset_n,
    input  logic             enable,
    output logic             hsync,
    output logic             vsync,
    output logic             blank_n,
    output logic [CNT_W-1:0] draw_x,
    output logic [CNT_W-1:0] draw_y,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    if ((2 ** CNT_W) < H_TOTAL || (2 ** CNT_W) < V_TOTAL) begin : g_bad_width
        $error("vga_timing_gen: CNT_W too narrow for the raster");
    end
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
        $error("vga_timing_gen: porch and sync widths must be non-zero");
    end

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;

    vga_axis_counter #(.MAX(H_TOTAL), .W(CNT_W)) u_h (
        .clk     (pixel_clk),
        .reset_n (reset_n),
        .inc     (enable),
        .count   (h_cnt),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(.MAX(V_TOTAL), .W(CNT_W)) u_v (
        .clk     (pixel_clk),
        .reset_n (reset_n),
        .inc     (enable & h_wrap),
        .count   (v_cnt),
        .wrap    (v_wrap)
    );

    // The vertical axis can only fold over on the last pixel of a line.
    always_comb begin
        if (v_wrap) assert (h_wrap);
    end

    logic             hsync_d;
    logic             vsync_d;
    logic             blank_n_d;
    logic             line_start_d;
    logic             frame_start_d;

    // Decode the current counter position into next-cycle output levels.
    always_comb begin
        hsync_d       = in_window(int'(h_cnt), H_SYNC_START, H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = in_window(int'(v_cnt), V_SYNC_START, V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        blank_n_d     = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
        line_start_d  = (h_cnt == '0);
        frame_start_d = (h_cnt == '0) && (v_cnt == '0);
    end

    // Register the decode; everything holds while enable is low.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            blank_n     <= 1'b0;
            draw_x      <= '0;
            draw_y      <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (enable) begin
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            blank_n     <= blank_n_d;
            draw_x      <= h_cnt;
            draw_y      <= v_cnt;
            line_start  <= line_start_d;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic pixel_clk;
    logic reset_n;
    logic en;

    logic       hs_a, vs_a, bn_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       hs_b, vs_b, bn_b, ls_b, fs_b;
    logic [3:0] x_b, y_b;
    logic       hs_c, vs_c, bn_c, ls_c, fs_c;
    logic [9:0] x_c, y_c;

    int total = 0;
    int bad   = 0;
    int k     = 0;

    vga_timing_gen dut_a (
        .pixel_clk(pixel_clk), .reset_n(reset_n), .enable(en),
        .hsync(hs_a), .vsync(vs_a), .blank_n(bn_a), .draw_x(x_a), .draw_y(y_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .CNT_W(4)
    ) dut_b (
        .pixel_clk(pixel_clk), .reset_n(reset_n), .enable(en),
        .hsync(hs_b), .vsync(vs_b), .blank_n(bn_b), .draw_x(x_b), .draw_y(y_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    vga_timing_gen #(.SYNC_POL(1'b1)) dut_c (
        .pixel_clk(pixel_clk), .reset_n(reset_n), .enable(en),
        .hsync(hs_c), .vsync(vs_c), .blank_n(bn_c), .draw_x(x_c), .draw_y(y_c),
        .line_start(ls_c), .frame_start(fs_c)
    );

    initial begin
        pixel_clk = 1'b0;
        forever #5 pixel_clk = ~pixel_clk;
    end

    function automatic logic [63:0] pack(input bit hs, input bit vs, input bit bn,
                                         input bit ls, input bit fs, input int x, input int y);
        return {27'b0, hs, vs, bn, ls, fs, x[15:0], y[15:0]};
    endfunction

    // Reference: after k enabled edges the outputs describe raster position k-1 of the
    // endless pixel sequence, laid out row-major over an ht x vt frame.
    function automatic logic [63:0] ref_out(input int kk, input int ha, input int hf, input int hsw,
                                            input int hb, input int va, input int vf, input int vsw,
                                            input int vb, input bit pol);
        int ht, vt, p, x, y;
        bit hs, vs;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (kk == 0) return pack(!pol, !pol, 1'b0, 1'b0, 1'b0, 0, 0);
        p  = (kk - 1) % (ht * vt);
        x  = p % ht;
        y  = p / ht;
        hs = (x >= ha + hf && x < ha + hf + hsw) ? pol : !pol;
        vs = (y >= va + vf && y < va + vf + vsw) ? pol : !pol;
        return pack(hs, vs, (x < ha && y < va), (x == 0), (p == 0), x, y);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] act_a();
        return pack(hs_a, vs_a, bn_a, ls_a, fs_a, int'(x_a), int'(y_a));
    endfunction
    function automatic logic [63:0] act_b();
        return pack(hs_b, vs_b, bn_b, ls_b, fs_b, int'(x_b), int'(y_b));
    endfunction
    function automatic logic [63:0] act_c();
        return pack(hs_c, vs_c, bn_c, ls_c, fs_c, int'(x_c), int'(y_c));
    endfunction

    // Count enabled edges since reset.
    always @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) k <= 0;
        else if (en)  k <= k + 1;
    end

    // Continuous stream comparison against the reference for every instance.
    always @(negedge pixel_clk) begin
        chk("stream_a", act_a(), ref_out(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
        chk("stream_b", act_b(), ref_out(k, 8, 2, 3, 2, 6, 1, 2, 1, 1'b0));
        chk("stream_c", act_c(), ref_out(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1));
    end

    task automatic tick(input bit e);
        en = e;
        @(posedge pixel_clk);
        @(negedge pixel_clk);
    endtask

    typedef struct {
        int adv;
        int x;
        int y;
        bit bn;
        bit hs;
        bit vs;
        bit ls;
        bit fs;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n_hs, n_bn, n_ls, n_fs, n_vs, n_hc;
        bit found;

        vecs[0] = '{1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{639, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1,   640, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{16,  656, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{95,  751, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1,   752, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{47,  799, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1,   0,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        en      = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge pixel_clk);
        chk("reset_a", act_a(), pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
        chk("reset_c", act_c(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0));
        reset_n = 1'b1;
        tick(1'b0);
        chk("idle_after_release", act_a(), pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));

        // First line of the default raster, stepped through its boundaries.
        for (int i = 0; i < 8; i++) begin
            repeat (vecs[i].adv) tick(1'b1);
            chk($sformatf("vec%0d", i), act_a(),
                pack(vecs[i].hs, vecs[i].vs, vecs[i].bn, vecs[i].ls, vecs[i].fs, vecs[i].x, vecs[i].y));
        end

        // One full visible line: sync width, visible span, one line strobe.
        n_hs = 0; n_bn = 0; n_ls = 0; n_hc = 0;
        for (int i = 0; i < 800; i++) begin
            tick(1'b1);
            if (!hs_a) n_hs++;
            if (bn_a)  n_bn++;
            if (ls_a)  n_ls++;
            if (hs_c)  n_hc++;
        end
        chk("line_hsync_low", 64'(n_hs), 64'(96));
        chk("line_blank_hi",  64'(n_bn), 64'(640));
        chk("line_strobes",   64'(n_ls), 64'(1));
        chk("line_hsync_c",   64'(n_hc), 64'(96));

        // One full frame of the small raster (15 x 10).
        n_fs = 0; n_ls = 0; n_vs = 0; n_bn = 0;
        for (int i = 0; i < 150; i++) begin
            tick(1'b1);
            if (fs_b)  n_fs++;
            if (ls_b)  n_ls++;
            if (!vs_b) n_vs++;
            if (bn_b)  n_bn++;
        end
        chk("frame_fs", 64'(n_fs), 64'(1));
        chk("frame_ls", 64'(n_ls), 64'(10));
        chk("frame_vs", 64'(n_vs), 64'(30));
        chk("frame_bn", 64'(n_bn), 64'(48));

        // Random enable pattern; the stream checker covers hold and sequence.
        for (int i = 0; i < 3000; i++) tick(1'(($urandom & 32'h1)));

        // Frame wrap on the small raster.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (x_b == 4'd14 && y_b == 4'd9) found = 1'b1;
            else tick(1'b1);
        end
        chk("wrap_reached", 64'(found), 64'(1));
        tick(1'b1);
        chk("wrap_next", act_b(), pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0));

        // Mid-frame asynchronous reset, applied between clock edges.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (x_b == 4'd4 && y_b == 4'd3) found = 1'b1;
            else tick(1'b1);
        end
        chk("mid_reached", 64'(found), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_a", act_a(), pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
        chk("async_rst_b", act_b(), pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
        chk("async_rst_c", act_c(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0));
        en = 1'b1;
        repeat (2) @(negedge pixel_clk);
        reset_n = 1'b1;
        tick(1'b1);
        chk("restart_b", act_b(), pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0));
        chk("restart_a", act_a(), pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0));
        repeat (20) tick(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
